// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
//
// Bundles every non-clock signal of alu_arbiter: the two-requester
// valid/ready request and response channels, the flag outputs, and the
// connection to the shared 16-bit ALU.
//
//   REQ_VALID/REQ_READY   per-requester request handshake (bit 0 = execute
//                         stage, bit 1 = address/aux unit)
//   REQ_A/REQ_B/REQ_OP    packed operands and selector, req0 in the low slice
//   RSP_VALID/RSP_READY   per-requester response handshake
//   RSP_OUT/RSP_FLAG      captured result and flags, shared bus
//   FLAG_REG              architectural {S,Z,C,V}
//   ALU_A/ALU_B/ALU_S     registered drive to the ALU
//   ALU_RES/ALU_FLAG/ALU_FWR  ALU result, flags and flag-write strobe
//   BUSY                  arbiter not idle
//
// Modports: slave = the arbiter, master = requesters plus ALU side.
// ---------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 4,
  parameter int FLAG_W = 4
);
  logic [1:0]          REQ_VALID;
  logic [1:0]          REQ_READY;
  logic [2*DATA_W-1:0] REQ_A;
  logic [2*DATA_W-1:0] REQ_B;
  logic [2*OP_W-1:0]   REQ_OP;
  logic [1:0]          RSP_VALID;
  logic [1:0]          RSP_READY;
  logic [DATA_W-1:0]   RSP_OUT;
  logic [FLAG_W-1:0]   RSP_FLAG;
  logic [FLAG_W-1:0]   FLAG_REG;
  logic [DATA_W-1:0]   ALU_A;
  logic [DATA_W-1:0]   ALU_B;
  logic [OP_W-1:0]     ALU_S;
  logic [DATA_W-1:0]   ALU_RES;
  logic [FLAG_W-1:0]   ALU_FLAG;
  logic                ALU_FWR;
  logic                BUSY;

  modport slave (
    input  REQ_VALID, REQ_A, REQ_B, REQ_OP, RSP_READY,
    input  ALU_RES, ALU_FLAG, ALU_FWR,
    output REQ_READY, RSP_VALID, RSP_OUT, RSP_FLAG, FLAG_REG,
    output ALU_A, ALU_B, ALU_S, BUSY
  );

  modport master (
    output REQ_VALID, REQ_A, REQ_B, REQ_OP, RSP_READY,
    output ALU_RES, ALU_FLAG, ALU_FWR,
    input  REQ_READY, RSP_VALID, RSP_OUT, RSP_FLAG, FLAG_REG,
    input  ALU_A, ALU_B, ALU_S, BUSY
  );
endinterface

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one 16-bit ALU between the execute stage (requester 0) and the
// address/aux unit (requester 1). One operation is in flight at a time and
// walks IDLE -> EXEC -> RESP -> IDLE. Ties in IDLE go to the requester
// holding priority, which flips to the other side after every issue. Only
// requester-0 results with the ALU flag-write strobe update FLAG_REG.
//
// Ports:
//   CLK    clock
//   RST_N  asynchronous active-low reset; discards any operation in flight
//   bus    alu_arbiter_if.slave (request/response channels, flags, ALU)
//
// Optional feature (macro ALU_ARB_MUL2_EN): an IMUL (selector 4'b0111)
// stays in EXEC for two cycles with operands held, capturing at the end of
// the second. With the macro undefined every op spends one cycle in EXEC.
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int              DATA_W = 16,
  parameter int              OP_W   = 4,
  parameter int              FLAG_W = 4,
  parameter logic [OP_W-1:0] OP_NON = 4'b1111
) (
  input logic         CLK,
  input logic         RST_N,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic                gid_q, gid_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d;
  logic [DATA_W-1:0]   alu_b_q, alu_b_d;
  logic [OP_W-1:0]     alu_s_q, alu_s_d;
  logic [DATA_W-1:0]   rsp_out_q, rsp_out_d;
  logic [FLAG_W-1:0]   rsp_flag_q, rsp_flag_d;
  logic [FLAG_W-1:0]   flag_reg_q, flag_reg_d;

`ifdef ALU_ARB_MUL2_EN
  localparam logic [OP_W-1:0] OP_MUL = 4'b0111;
  // Set after the first IMUL cycle; the second cycle is the capture cycle.
  logic                mul_cnt_q, mul_cnt_d;
`endif

  logic                grant;
  logic [1:0]          req_ready;
  logic                exec_done;

  // Sole valid requester wins; on a tie the priority holder wins.
  always_comb begin
    grant = bus.REQ_VALID[1];
    if (bus.REQ_VALID == 2'b11) begin
      grant = prio_q;
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if (state_q == ST_IDLE && bus.REQ_VALID != 2'b00) begin
      req_ready = grant ? 2'b10 : 2'b01;
    end
  end

`ifdef ALU_ARB_MUL2_EN
  assign exec_done = !(alu_s_q == OP_MUL && !mul_cnt_q);
`else
  assign exec_done = 1'b1;
`endif

  // NOTE: every variable written here gets its default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    gid_d      = gid_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_s_d    = alu_s_q;
    rsp_out_d  = rsp_out_q;
    rsp_flag_d = rsp_flag_q;
    flag_reg_d = flag_reg_q;
`ifdef ALU_ARB_MUL2_EN
    mul_cnt_d  = mul_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if ((bus.REQ_VALID & req_ready) != 2'b00) begin
          alu_a_d = grant ? bus.REQ_A[2*DATA_W-1:DATA_W] : bus.REQ_A[DATA_W-1:0];
          alu_b_d = grant ? bus.REQ_B[2*DATA_W-1:DATA_W] : bus.REQ_B[DATA_W-1:0];
          alu_s_d = grant ? bus.REQ_OP[2*OP_W-1:OP_W]    : bus.REQ_OP[OP_W-1:0];
          gid_d   = grant;
          state_d = ST_EXEC;
`ifdef ALU_ARB_MUL2_EN
          mul_cnt_d = 1'b0;
`endif
        end
      end

      ST_EXEC: begin
        if (!exec_done) begin
`ifdef ALU_ARB_MUL2_EN
          mul_cnt_d = 1'b1;
`endif
        end else begin
          // A no-op returns zero and never touches the architectural flags,
          // whatever the ALU happens to drive for that selector.
          rsp_out_d  = (alu_s_q == OP_NON) ? '0 : bus.ALU_RES;
          rsp_flag_d = bus.ALU_FLAG;
          if (!gid_q && bus.ALU_FWR && alu_s_q != OP_NON) begin
            flag_reg_d = bus.ALU_FLAG;
          end
          prio_d  = ~gid_q;
          alu_s_d = OP_NON;
          state_d = ST_RESP;
        end
      end

      ST_RESP: begin
        // Only the owner's RSP_READY completes the response.
        if (bus.RSP_READY[gid_q]) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  // NOTE: all state here is plain flops (no memory arrays), so every one is
  // reset; this is what makes a mid-operation reset drop the op cleanly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      prio_q     <= 1'b0;
      gid_q      <= 1'b0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_s_q    <= OP_NON;
      rsp_out_q  <= '0;
      rsp_flag_q <= '0;
      flag_reg_q <= '0;
`ifdef ALU_ARB_MUL2_EN
      mul_cnt_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      gid_q      <= gid_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_s_q    <= alu_s_d;
      rsp_out_q  <= rsp_out_d;
      rsp_flag_q <= rsp_flag_d;
      flag_reg_q <= flag_reg_d;
`ifdef ALU_ARB_MUL2_EN
      mul_cnt_q  <= mul_cnt_d;
`endif
    end
  end

  assign bus.REQ_READY = req_ready;
  assign bus.RSP_VALID = (state_q == ST_RESP) ? (gid_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.RSP_OUT   = rsp_out_q;
  assign bus.RSP_FLAG  = rsp_flag_q;
  assign bus.FLAG_REG  = flag_reg_q;
  assign bus.ALU_A     = alu_a_q;
  assign bus.ALU_B     = alu_b_q;
  assign bus.ALU_S     = alu_s_q;
  assign bus.BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives alu_arbiter with directed and random traffic. A behavioural ALU
// answers the arbiter's ALU port. A transaction-level reference tracks the
// round-robin priority, the outstanding op, its expected result/flags and
// latency, and the architectural flag register, and is compared every
// cycle. Honours ALU_ARB_MUL2_EN for the IMUL latency.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;
  localparam int FLAG_W = 4;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h7;
  localparam logic [3:0] OP_NON = 4'hF;
`ifdef ALU_ARB_MUL2_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 2;
`endif

  logic CLK = 1'b0;
  logic RST_N = 1'b0;

  alu_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W), .FLAG_W(FLAG_W)) bus ();

  alu_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .FLAG_W(FLAG_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU: returns {fwr, {S,Z,C,V}, result}.
  function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [3:0] s);
    logic [16:0] w;
    logic [31:0] p;
    logic [15:0] r;
    logic        c, v, fwr;
    c = 1'b0; v = 1'b0; fwr = 1'b1; w = '0; p = '0;
    case (s)
      4'h0: begin
        w = {1'b0, a} + {1'b0, b};
        r = w[15:0]; c = w[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      4'h1: begin
        r = a - b; c = (a < b);
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h7: begin p = a * b; r = p[15:0]; end
      4'hF: begin r = 16'h0000; fwr = 1'b0; end
      default: r = a;
    endcase
    return {fwr, r[15], (r == 16'h0000), c, v, r};
  endfunction

  always_comb {bus.ALU_FWR, bus.ALU_FLAG, bus.ALU_RES} = alu_fn(bus.ALU_A, bus.ALU_B, bus.ALU_S);

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference-model state.
  logic        m_prio, m_flag_valid;
  logic [3:0]  m_flag;
  logic        pend, pend_gid, first;
  logic [15:0] exp_out;
  logic [3:0]  exp_flag;
  int          exp_lat, acc_cyc, last_lat;
  int          cyc = 0;
  int          done_cnt = 0;
  logic [15:0] last_out;
  logic [3:0]  last_flag;
  int          grant_q[$];

  // Stimulus control and last sampled values.
  int          auto_rate = 0;
  int          drop_rate = 0;
  bit          rsp_rand  = 1'b0;
  logic [1:0]  s_acc, s_ready, s_rsp_v;
  logic [15:0] s_rsp_out;

  task automatic monitor();
    logic [1:0]  exp_rdy;
    logic [1:0]  acc;
    logic        g;
    logic [3:0]  op;
    logic [20:0] e;
    if (!RST_N) begin
      m_prio = 1'b0; m_flag = 4'h0; pend = 1'b0; first = 1'b0;
      return;
    end
    check("rdy_not_both", (bus.REQ_READY == 2'b11), 1'b0);
    check("busy", bus.BUSY, pend);
    if (pend) begin
      check("rdy_busy", bus.REQ_READY, 2'b00);
      if (bus.RSP_VALID != 2'b00) begin
        check("rsp_valid", bus.RSP_VALID, pend_gid ? 2'b10 : 2'b01);
        check("rsp_out", bus.RSP_OUT, exp_out);
        check("rsp_flag", bus.RSP_FLAG, exp_flag);
        check("flag_reg_rsp", bus.FLAG_REG, m_flag);
        if (first) begin
          check("latency", cyc - acc_cyc, exp_lat);
          last_lat = cyc - acc_cyc;
          first = 1'b0;
        end
        if (bus.RSP_READY[pend_gid]) begin
          pend = 1'b0;
          done_cnt++;
          last_out  = bus.RSP_OUT;
          last_flag = bus.RSP_FLAG;
        end
      end
    end else begin
      check("rsp_stale", bus.RSP_VALID, 2'b00);
      check("flag_reg_idle", bus.FLAG_REG, m_flag);
      if (bus.REQ_VALID == 2'b11) exp_rdy = m_prio ? 2'b10 : 2'b01;
      else                        exp_rdy = bus.REQ_VALID;
      check("rdy_idle", bus.REQ_READY, exp_rdy);
      acc = bus.REQ_VALID & bus.REQ_READY;
      if (acc != 2'b00) begin
        g  = acc[1];
        op = bus.REQ_OP[g*4 +: 4];
        e  = alu_fn(bus.REQ_A[g*16 +: 16], bus.REQ_B[g*16 +: 16], op);
        exp_out  = e[15:0];
        exp_flag = e[19:16];
        if (!g && e[20]) m_flag = e[19:16];
        m_prio   = ~g;
        pend     = 1'b1;
        pend_gid = g;
        first    = 1'b1;
        acc_cyc  = cyc;
        exp_lat  = (op == OP_MUL) ? MUL_LAT : 2;
        grant_q.push_back(int'(g));
      end
    end
  endtask

  task automatic set_req(input int r, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op);
    bus.REQ_A[r*16 +: 16] = a;
    bus.REQ_B[r*16 +: 16] = b;
    bus.REQ_OP[r*4 +: 4]  = op;
    bus.REQ_VALID[r]      = 1'b1;
  endtask

  task automatic rand_req(input int r);
    logic [15:0] a, b;
    a = ($urandom_range(3) == 0) ? 16'h7FFF : 16'($urandom);
    b = ($urandom_range(3) == 0) ? a        : 16'($urandom);
    set_req(r, a, b, 4'($urandom_range(15)));
  endtask

  // One clock: model + sampling on the falling edge, drive after the rise.
  task automatic step();
    @(negedge CLK);
    monitor();
    s_acc     = bus.REQ_VALID & bus.REQ_READY;
    s_ready   = bus.REQ_READY;
    s_rsp_v   = bus.RSP_VALID;
    s_rsp_out = bus.RSP_OUT;
    @(posedge CLK);
    #1;
    cyc++;
    for (int r = 0; r < 2; r++) begin
      if (s_acc[r]) bus.REQ_VALID[r] = 1'b0;
      if (auto_rate > 0) begin
        if (!bus.REQ_VALID[r]) begin
          if ($urandom_range(99) < auto_rate) rand_req(r);
        end else if ($urandom_range(99) < drop_rate) begin
          bus.REQ_VALID[r] = 1'b0;
        end
      end
    end
    if (rsp_rand) bus.RSP_READY = 2'($urandom_range(3));
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) step();
    check("done_timeout", (done_cnt >= target), 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && pend; i++) step();
    check("idle_timeout", pend, 1'b0);
  endtask

  task automatic do_op(input int r, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] op);
    set_req(r, a, b, op);
    wait_done(done_cnt + 1, 50);
  endtask

  initial begin
    int          base;
    logic [15:0] hold;
    bus.REQ_VALID = 2'b00;
    bus.REQ_A     = '0;
    bus.REQ_B     = '0;
    bus.REQ_OP    = '0;
    bus.RSP_READY = 2'b00;

    // Reset values.
    RST_N = 1'b0;
    step();
    step();
    check("rst_req_ready", bus.REQ_READY, 2'b00);
    check("rst_rsp_valid", bus.RSP_VALID, 2'b00);
    check("rst_rsp_out",   bus.RSP_OUT,   16'h0000);
    check("rst_rsp_flag",  bus.RSP_FLAG,  4'h0);
    check("rst_flag_reg",  bus.FLAG_REG,  4'h0);
    check("rst_alu_a",     bus.ALU_A,     16'h0000);
    check("rst_alu_b",     bus.ALU_B,     16'h0000);
    check("rst_alu_s",     bus.ALU_S,     4'hF);
    check("rst_busy",      bus.BUSY,      1'b0);
    RST_N = 1'b1;
    bus.RSP_READY = 2'b11;
    step();

    // Req0 ADD overflow to 0x8000.
    do_op(0, 16'h7FFF, 16'h0001, OP_ADD);
    check("add_out",  last_out,     16'h8000);
    check("add_flag", last_flag,    4'b1001);
    check("add_freg", bus.FLAG_REG, 4'b1001);
    check("add_lat",  last_lat,     2);

    // Req1 SUB to zero: flags returned, FLAG_REG untouched.
    do_op(1, 16'd5, 16'd5, OP_SUB);
    check("sub_out",  last_out,     16'h0000);
    check("sub_z",    last_flag[2], 1'b1);
    check("sub_freg", bus.FLAG_REG, 4'b1001);

    // Req0 no-op: zero result, FLAG_REG untouched.
    do_op(0, 16'h1234, 16'h5678, OP_NON);
    check("non_out",  last_out,     16'h0000);
    check("non_freg", bus.FLAG_REG, 4'b1001);

    // IMUL latency (two EXEC cycles only with the optional feature).
    do_op(0, 16'd3, 16'd4, OP_MUL);
    check("mul_out", last_out, 16'd12);
    check("mul_lat", last_lat, MUL_LAT);
    do_op(0, 16'd2, 16'd2, OP_ADD);
    check("add2_lat", last_lat, 2);

    // Reset during EXEC: op dropped, no response afterwards.
    do_op(0, 16'h7FFF, 16'h0001, OP_ADD);
    set_req(0, 16'h7FFF, 16'h0001, OP_ADD);
    s_acc = 2'b00;
    for (int i = 0; i < 10 && !s_acc[0]; i++) step();
    check("midrst_acc", s_acc[0], 1'b1);
    RST_N = 1'b0;
    step();
    check("midrst_busy",  bus.BUSY,      1'b0);
    check("midrst_rspv",  bus.RSP_VALID, 2'b00);
    check("midrst_freg",  bus.FLAG_REG,  4'h0);
    check("midrst_alu_s", bus.ALU_S,     4'hF);
    RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("midrst_no_rsp", s_rsp_v, 2'b00);
    end

    // Both requesters continuously valid: strict alternation from 0.
    base = grant_q.size();
    auto_rate = 100;
    wait_done(done_cnt + 6, 100);
    auto_rate = 0;
    bus.REQ_VALID = 2'b00;
    wait_idle(20);
    for (int i = 0; i < 6; i++) begin
      if (base + i < grant_q.size()) check("alt_grant", grant_q[base + i], i % 2);
      else                           check("alt_missing", grant_q.size(), base + 6);
    end

    // Response back-pressure on req0 while req1 waits.
    bus.RSP_READY = 2'b10;
    base = done_cnt;
    set_req(0, 16'h0001, 16'h0002, OP_ADD);
    s_acc = 2'b00;
    for (int i = 0; i < 10 && !s_acc[0]; i++) step();
    check("bp_acc0", s_acc[0], 1'b1);
    set_req(1, 16'h0009, 16'h0003, OP_SUB);
    s_rsp_v = 2'b00;
    for (int i = 0; i < 10 && !s_rsp_v[0]; i++) step();
    check("bp_rspv", s_rsp_v, 2'b01);
    hold = s_rsp_out;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_v",   s_rsp_v,   2'b01);
      check("bp_hold_out", s_rsp_out, hold);
      check("bp_no_acc1",  s_acc[1],  1'b0);
    end
    check("bp_val", hold, 16'h0003);
    bus.RSP_READY = 2'b11;
    wait_done(base + 2, 30);
    check("bp_then_req1", grant_q[grant_q.size() - 1], 1);

    // Random traffic with random response back-pressure.
    auto_rate = 50;
    drop_rate = 3;
    rsp_rand  = 1'b1;
    wait_done(done_cnt + 150, 4000);
    auto_rate = 0;
    rsp_rand  = 1'b0;
    bus.REQ_VALID = 2'b00;
    bus.RSP_READY = 2'b11;
    wait_idle(20);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
